// File: rtl/rr_arbiter_8_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// Holds the FSM state encoding and the requester/index sizing.
package rr_arbiter_8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/decoder_3_to_8.sv
// Binary index to one-hot decoder used to build the arbiter grant vector.
module decoder_3_to_8 (
    input  logic [2:0] idx,
    output logic [7:0] onehot
);

    always_comb begin
        onehot      = 8'h00;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with a bounded hold time per grant.
// Two-state FSM (IDLE/BUSY); every output is a flop, state is visible on fsm_state.
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout,
    output state_e           fsm_state
);

    // Handshake: a requester raises req[k] and keeps it high while it wants the
    // resource; grant[k] rises one cycle after the sampling edge and stays until
    // the owner pulses done, drops req[k], or the hold limit expires. After any
    // release exactly one idle cycle precedes the next grant.

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [7:0]         hold_q, hold_d;
    logic [IDX_W-1:0]   idx_d;
    logic               valid_d;
    logic               timeout_d;
    logic [N_REQ-1:0]   grant_d;
    logic [N_REQ-1:0]   dec_onehot;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic               vol_release;
    logic               hold_expired;

    // Rotating priority search: first set request starting at ptr, wrapping mod 8.
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            logic [IDX_W-1:0] cand;
            cand = ptr_q + IDX_W'(i);
            if (!pick_found && req[cand]) begin
                pick_idx   = cand;
                pick_found = 1'b1;
            end
        end
    end

    assign vol_release  = done || !req[grant_idx];
    assign hold_expired = (hold_q == HOLD_LAST);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        idx_d     = grant_idx;
        valid_d   = grant_valid;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                idx_d   = '0;
                valid_d = 1'b0;
                hold_d  = '0;
                if (pick_found) begin
                    state_d = BUSY;
                    idx_d   = pick_idx;
                    valid_d = 1'b1;
                end
            end
            BUSY: begin
                if (vol_release || hold_expired) begin
                    state_d   = IDLE;
                    idx_d     = '0;
                    valid_d   = 1'b0;
                    hold_d    = '0;
                    ptr_d     = grant_idx + IDX_W'(1);
                    // A voluntary release on the limit edge is not a timeout.
                    timeout_d = hold_expired && !vol_release;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                valid_d = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

    // Decode the next index so grant can be registered alongside grant_idx.
    decoder_3_to_8 u_decoder (
        .idx    (idx_d),
        .onehot (dec_onehot)
    );

    assign grant_d = valid_d ? dec_onehot : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_q      <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
            grant       <= grant_d;
            grant_idx   <= idx_d;
            grant_valid <= valid_d;
            timeout     <= timeout_d;
        end
    end

    assign fsm_state = state_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed self-checking bench for rr_arbiter_8 with hand-computed expectations.
module tb_rr_arbiter_8;
    import rr_arbiter_8_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;
    state_e     fsm_state;

    int checks = 0;
    int errors = 0;

    rr_arbiter_8 #(.HOLD_MAX(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout),
        .fsm_state   (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled off the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic check_grant(input string tag, input logic [7:0] g, input logic [2:0] idx,
                               input logic v, input logic t);
        check({tag, "_grant"}, grant, g);
        check({tag, "_idx"}, {5'b0, grant_idx}, {5'b0, idx});
        check({tag, "_valid"}, {7'b0, grant_valid}, {7'b0, v});
        check({tag, "_timeout"}, {7'b0, timeout}, {7'b0, t});
    endtask

    initial begin
        logic [7:0] exp_g;
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        #12;
        check_grant("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        check("reset_state", {7'b0, fsm_state}, {7'b0, IDLE});
        rst_n = 1'b1;

        // Idle with no requests stays quiet.
        step();
        check_grant("idle_noreq", 8'h00, 3'd0, 1'b0, 1'b0);

        // Two requesters alternate 0,7,0 with an idle cycle between grants.
        req = 8'h81;
        step(); check_grant("alt0", 8'h01, 3'd0, 1'b1, 1'b0);
        check("alt0_state", {7'b0, fsm_state}, {7'b0, BUSY});
        done = 1'b1;
        step(); check_grant("alt0_rel", 8'h00, 3'd0, 1'b0, 1'b0);
        done = 1'b0;
        step(); check_grant("alt7", 8'h80, 3'd7, 1'b1, 1'b0);
        done = 1'b1;
        step(); check_grant("alt7_rel", 8'h00, 3'd0, 1'b0, 1'b0);
        done = 1'b0;
        step(); check_grant("alt0b", 8'h01, 3'd0, 1'b1, 1'b0);
        done = 1'b1;
        step(); check_grant("alt0b_rel", 8'h00, 3'd0, 1'b0, 1'b0);
        done = 1'b0;

        // All requesting: full rotation 0..7 then wrap to 0.
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            exp_g = 8'h01 << (k % 8);
            step(); check_grant("rot", exp_g, 3'(k % 8), 1'b1, 1'b0);
            done = 1'b1;
            step(); check_grant("rot_rel", 8'h00, 3'd0, 1'b0, 1'b0);
            done = 1'b0;
        end

        // Single requester never releasing: 16 cycles, timeout pulse, re-grant.
        do_reset();
        req = 8'h04;
        for (int k = 0; k < 16; k++) begin
            step(); check_grant("hold", 8'h04, 3'd2, 1'b1, 1'b0);
        end
        step(); check_grant("hold_to", 8'h00, 3'd0, 1'b0, 1'b1);
        step(); check_grant("hold_regrant", 8'h04, 3'd2, 1'b1, 1'b0);

        // done on the limit edge: release without a timeout pulse.
        for (int k = 0; k < 15; k++) begin
            step(); check_grant("lim_hold", 8'h04, 3'd2, 1'b1, 1'b0);
        end
        done = 1'b1;
        step(); check_grant("lim_done", 8'h00, 3'd0, 1'b0, 1'b0);
        done = 1'b0;
        step(); check_grant("lim_regrant", 8'h04, 3'd2, 1'b1, 1'b0);
        req = 8'h00;
        step(); check_grant("lim_drop", 8'h00, 3'd0, 1'b0, 1'b0);
        step(); check_grant("lim_idle", 8'h00, 3'd0, 1'b0, 1'b0);

        // Owner 3 keeps grant while others change, then drops req; 5 follows.
        do_reset();
        req = 8'h28;
        step(); check_grant("own3", 8'h08, 3'd3, 1'b1, 1'b0);
        req = 8'hE8;
        step(); check_grant("own3_others", 8'h08, 3'd3, 1'b1, 1'b0);
        req = 8'h20;
        step(); check_grant("own3_drop", 8'h00, 3'd0, 1'b0, 1'b0);
        step(); check_grant("own5", 8'h20, 3'd5, 1'b1, 1'b0);

        // Asynchronous reset mid-grant, then arbitration restarts from ptr 0.
        do_reset();
        req = 8'h10;
        step(); check_grant("pre_rst", 8'h10, 3'd4, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_grant("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        req = 8'h30;
        #2;
        rst_n = 1'b1;
        step(); check_grant("post_rst", 8'h10, 3'd4, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
